tof_pulse_detector: RTL and testbench

Time-of-flight pulse detector for the rangefinder receive path. It consumes the summed 8-bit receive waveform, which carries one start pulse, up to several echo (stop) pulses and additive noise. After `arm` it finds the start pulse, then qualifies each later stop pulse with threshold, hysteresis and minimum width, and reports each stop's peak amplitude and its peak-to-peak delay from the start pulse in clock cycles.

---
 rtl/tof_pulse_detector.sv | 215 +++++++++++++++++++++
 tb/tb_tof_pulse_detector.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tof_pulse_detector.sv
// Time-of-flight pulse detector: finds the start pulse after arm, then reports each
// qualified stop pulse's peak amplitude and peak-to-peak delay from the start peak.
module tof_pulse_detector #(
  parameter int THRESH    = 40,
  parameter int HYST      = 8,
  parameter int MIN_WIDTH = 3,
  parameter int MAX_STOPS = 5,
  parameter int WINDOW    = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  sample,
  input  logic        arm,
  output logic        busy,
  output logic        stop_valid,
  output logic [2:0]  stop_idx,
  output logic [15:0] tof,
  output logic [7:0]  stop_amp,
  output logic [7:0]  start_amp,
  output logic        done,
  output logic [2:0]  stop_count,
  output logic        timeout
);

  localparam logic [7:0]  TH_HI   = 8'(THRESH);
  localparam logic [7:0]  TH_LO   = 8'(THRESH - HYST);
  localparam logic [7:0]  MIN_W   = 8'(MIN_WIDTH);
  localparam logic [2:0]  N_STOPS = 3'(MAX_STOPS);
  localparam logic [15:0] T_LAST  = 16'(WINDOW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_START,
    S_IN_START,
    S_WAIT_STOP,
    S_IN_STOP
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [15:0] r_t;
  logic [7:0]  r_peak;
  logic [15:0] r_peak_tag;
  logic [7:0]  r_width;
  logic [15:0] r_start_tag;
  logic        r_busy;
  logic        r_stop_valid;
  logic [2:0]  r_stop_idx;
  logic [15:0] r_tof;
  logic [7:0]  r_stop_amp;
  logic [7:0]  r_start_amp;
  logic        r_done;
  logic [2:0]  r_stop_count;
  logic        r_timeout;

  logic w_above;
  logic w_below;
  logic w_last;
  logic w_qualified;
  logic w_in_pulse;
  logic w_arm_accept;
  logic w_open;
  logic w_close_start;
  logic w_close_stop;
  logic w_finish_full;
  logic w_expire;
  logic w_done;

  assign w_above     = (sample >= TH_HI);
  assign w_below     = (sample < TH_LO);
  assign w_last      = (r_t == T_LAST);
  assign w_qualified = (r_width >= MIN_W);
  assign w_in_pulse  = (r_state == S_IN_START) || (r_state == S_IN_STOP);
  assign w_done      = w_finish_full | w_expire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    w_state_nxt   = r_state;
    w_arm_accept  = 1'b0;
    w_open        = 1'b0;
    w_close_start = 1'b0;
    w_close_stop  = 1'b0;
    w_finish_full = 1'b0;
    w_expire      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (arm) begin
          w_arm_accept = 1'b1;
          w_state_nxt  = S_WAIT_START;
        end
      end
      S_WAIT_START: begin
        if (w_above) begin
          w_open      = 1'b1;
          w_state_nxt = S_IN_START;
        end
      end
      S_IN_START: begin
        if (w_below) begin
          if (w_qualified) begin
            w_close_start = 1'b1;
            w_state_nxt   = S_WAIT_STOP;
          end else begin
            w_state_nxt = S_WAIT_START;
          end
        end
      end
      S_WAIT_STOP: begin
        if (w_above) begin
          w_open      = 1'b1;
          w_state_nxt = S_IN_STOP;
        end
      end
      S_IN_STOP: begin
        if (w_below) begin
          if (w_qualified) begin
            w_close_stop = 1'b1;
            if (r_stop_count + 3'd1 == N_STOPS) begin
              w_finish_full = 1'b1;
              w_state_nxt   = S_IDLE;
            end else begin
              w_state_nxt = S_WAIT_STOP;
            end
          end else begin
            w_state_nxt = S_WAIT_STOP;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // The expiry sample still closes and reports a pulse; only a full count beats the timeout.
    if ((r_state != S_IDLE) && w_last && !w_finish_full) begin
      w_expire    = 1'b1;
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_t          <= '0;
      r_peak       <= '0;
      r_peak_tag   <= '0;
      r_width      <= '0;
      r_start_tag  <= '0;
      r_busy       <= 1'b0;
      r_stop_valid <= 1'b0;
      r_stop_idx   <= '0;
      r_tof        <= '0;
      r_stop_amp   <= '0;
      r_start_amp  <= '0;
      r_done       <= 1'b0;
      r_stop_count <= '0;
      r_timeout    <= 1'b0;
    end else begin
      r_stop_valid <= w_close_stop;
      r_done       <= w_done;

      if (w_arm_accept) begin
        r_t          <= '0;
        r_start_amp  <= '0;
        r_stop_count <= '0;
        r_timeout    <= 1'b0;
        r_busy       <= 1'b1;
      end else if (r_state != S_IDLE) begin
        r_t <= r_t + 16'd1;
      end

      if (w_done)   r_busy    <= 1'b0;
      if (w_expire) r_timeout <= 1'b1;

      if (w_open) begin
        r_peak     <= sample;
        r_peak_tag <= r_t;
        r_width    <= 8'd1;
      end else if (w_in_pulse && !w_below) begin
        if (r_width != 8'hFF) r_width <= r_width + 8'd1;
        // Strict compare keeps the first of equal maxima.
        if (sample > r_peak) begin
          r_peak     <= sample;
          r_peak_tag <= r_t;
        end
      end

      if (w_close_start) begin
        r_start_amp <= r_peak;
        r_start_tag <= r_peak_tag;
      end

      if (w_close_stop) begin
        r_stop_idx   <= r_stop_count;
        r_tof        <= r_peak_tag - r_start_tag;
        r_stop_amp   <= r_peak;
        r_stop_count <= r_stop_count + 3'd1;
      end
    end
  end

  assign busy       = r_busy;
  assign stop_valid = r_stop_valid;
  assign stop_idx   = r_stop_idx;
  assign tof        = r_tof;
  assign stop_amp   = r_stop_amp;
  assign start_amp  = r_start_amp;
  assign done       = r_done;
  assign stop_count = r_stop_count;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_tof_pulse_detector.sv
// Self-checking bench for tof_pulse_detector: hand sequences, a vector table and
// randomized waveforms checked against a pulse-segment reference model.
`timescale 1ns/1ps
module tb_tof_pulse_detector;

  localparam int THRESH    = 40;
  localparam int HYST      = 8;
  localparam int MIN_WIDTH = 3;
  localparam int MAX_STOPS = 5;
  localparam int WINDOW    = 1000;
  localparam int WAVE_LEN  = 1200;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  sample;
  logic        arm;
  logic        busy;
  logic        stop_valid;
  logic [2:0]  stop_idx;
  logic [15:0] tof;
  logic [7:0]  stop_amp;
  logic [7:0]  start_amp;
  logic        done;
  logic [2:0]  stop_count;
  logic        timeout;

  tof_pulse_detector #(
    .THRESH(THRESH), .HYST(HYST), .MIN_WIDTH(MIN_WIDTH),
    .MAX_STOPS(MAX_STOPS), .WINDOW(WINDOW)
  ) dut (
    .clk(clk), .reset(reset), .sample(sample), .arm(arm),
    .busy(busy), .stop_valid(stop_valid), .stop_idx(stop_idx), .tof(tof),
    .stop_amp(stop_amp), .start_amp(start_amp), .done(done),
    .stop_count(stop_count), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] wave [0:WAVE_LEN-1];

  int obs_idx[$], obs_tof[$], obs_amp[$], obs_tag[$];
  int exp_idx[$], exp_tof[$], exp_amp[$], exp_tag[$];
  int obs_done_tag, obs_timeout, obs_busy_done, obs_extra;
  int exp_done_tag, exp_timeout, exp_start_amp;

  typedef struct {
    int t0; int w0; int k0;
    int t1; int w1; int k1;
    int t2; int w2; int k2;
    int e_cnt; int e_tof; int e_amp; int e_samp;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic clear_wave();
    for (int i = 0; i < WAVE_LEN; i++) wave[i] = 8'd0;
  endtask

  task automatic put6(input int t, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                      input logic [7:0] d, input logic [7:0] e, input logic [7:0] f);
    wave[t] = a; wave[t+1] = b; wave[t+2] = c; wave[t+3] = d; wave[t+4] = e; wave[t+5] = f;
  endtask

  // Flat-topped pulse at THRESH with the given peak on its last sample.
  task automatic put_pulse(input int t, input int w, input int pk);
    if (w > 0) begin
      for (int i = 0; i < w - 1; i++) wave[t+i] = 8'(THRESH);
      wave[t+w-1] = 8'(pk);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".busy"},       busy,       0);
    check({tag, ".stop_valid"}, stop_valid, 0);
    check({tag, ".stop_idx"},   stop_idx,   0);
    check({tag, ".tof"},        tof,        0);
    check({tag, ".stop_amp"},   stop_amp,   0);
    check({tag, ".start_amp"},  start_amp,  0);
    check({tag, ".done"},       done,       0);
    check({tag, ".stop_count"}, stop_count, 0);
    check({tag, ".timeout"},    timeout,    0);
  endtask

  // Reference: scan the waveform as a list of pulse segments [open, close).
  task automatic run_model();
    int t, e, pk, pt, start_tag, cnt;
    bit have_start;
    exp_idx.delete(); exp_tof.delete(); exp_amp.delete(); exp_tag.delete();
    exp_done_tag = -1; exp_timeout = 0; exp_start_amp = 0;
    t = 0; cnt = 0; have_start = 0; start_tag = 0;
    while (t < WINDOW && exp_done_tag < 0) begin
      if (int'(wave[t]) >= THRESH) begin
        e = t + 1; pk = int'(wave[t]); pt = t;
        while (e < WINDOW && int'(wave[e]) >= THRESH - HYST) begin
          if (int'(wave[e]) > pk) begin pk = int'(wave[e]); pt = e; end
          e++;
        end
        if (e >= WINDOW) break;
        if (e - t >= MIN_WIDTH) begin
          if (!have_start) begin
            have_start = 1; start_tag = pt; exp_start_amp = pk;
          end else begin
            exp_idx.push_back(cnt);
            exp_tof.push_back((pt - start_tag) & 16'hFFFF);
            exp_amp.push_back(pk);
            exp_tag.push_back(e);
            cnt++;
            if (cnt == MAX_STOPS) begin exp_done_tag = e; exp_timeout = 0; end
          end
        end
        t = e + 1;
      end else begin
        t++;
      end
    end
    if (exp_done_tag < 0) begin exp_done_tag = WINDOW - 1; exp_timeout = 1; end
  endtask

  // Arm, stream wave[] tagged from 0, record strobes by tag, then run extra cycles.
  task automatic run_meas(input int extra);
    int k;
    k = 0;
    obs_idx.delete(); obs_tof.delete(); obs_amp.delete(); obs_tag.delete();
    obs_done_tag = -1; obs_timeout = -1; obs_busy_done = -1; obs_extra = 0;
    @(negedge clk); arm = 1'b1; sample = 8'd0;
    @(negedge clk); arm = 1'b0;
    check("busy_after_arm", busy, 1);
    sample = wave[0];
    while (obs_done_tag < 0 && k < WINDOW + 8) begin
      @(negedge clk);
      if (stop_valid) begin
        obs_idx.push_back(int'(stop_idx)); obs_tof.push_back(int'(tof));
        obs_amp.push_back(int'(stop_amp)); obs_tag.push_back(k);
      end
      if (done) begin obs_done_tag = k; obs_timeout = int'(timeout); obs_busy_done = int'(busy); end
      k++;
      sample = (k < WAVE_LEN) ? wave[k] : 8'd0;
    end
    check("done_within_budget", obs_done_tag >= 0, 1);
    for (int j = 0; j < extra; j++) begin
      @(negedge clk);
      if (stop_valid || done) obs_extra++;
      k++;
      sample = (k < WAVE_LEN) ? wave[k] : 8'd0;
    end
    sample = 8'd0;
  endtask

  task automatic compare(input string tag);
    check({tag, ".n_stops"}, obs_tof.size(), exp_tof.size());
    for (int i = 0; i < obs_tof.size() && i < exp_tof.size(); i++) begin
      check($sformatf("%s.idx%0d", tag, i),  obs_idx[i], exp_idx[i]);
      check($sformatf("%s.tof%0d", tag, i),  obs_tof[i], exp_tof[i]);
      check($sformatf("%s.amp%0d", tag, i),  obs_amp[i], exp_amp[i]);
      check($sformatf("%s.when%0d", tag, i), obs_tag[i], exp_tag[i]);
    end
    check({tag, ".done_tag"},   obs_done_tag,  exp_done_tag);
    check({tag, ".timeout"},    obs_timeout,   exp_timeout);
    check({tag, ".busy_done"},  obs_busy_done, 0);
    check({tag, ".stop_count"}, stop_count,    exp_idx.size());
    check({tag, ".start_amp"},  start_amp,     exp_start_amp);
    check({tag, ".extra"},      obs_extra,     0);
    check({tag, ".busy_end"},   busy,          0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{10, 3, 90,   40, 3, 70,   0, 0, 0,    1, 30, 70, 90};
    vecs[1] = '{5, 2, 90,    20, 4, 100,  50, 3, 40,  1, 27, 40, 100};
    vecs[2] = '{10, 3, 60,   30, 2, 200,  60, 5, 41,  1, 52, 41, 60};
    vecs[3] = '{0, 3, 255,   0, 0, 0,     0, 0, 0,    0, 0, 0, 255};
    vecs[4] = '{20, 1, 250,  0, 0, 0,     0, 0, 0,    0, 0, 0, 0};
    vecs[5] = '{10, 3, 50,   996, 3, 77,  0, 0, 0,    1, 986, 77, 50};
    vecs[6] = '{10, 3, 50,   997, 3, 80,  0, 0, 0,    0, 0, 0, 50};

    // Reset with hostile inputs, then release with arm held.
    reset = 1'b0; sample = 8'd200; arm = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    #1 check("busy_before_arm_edge", busy, 0);
    @(negedge clk);
    check("busy_after_release_arm", busy, 1);
    arm = 1'b0; sample = 8'd0;
    reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    check_all_zero("reset2");

    // Start plus one stop.
    clear_wave();
    put6(10, 20, 50, 90, 60, 20, 0);
    put6(40, 10, 45, 70, 45, 10, 0);
    run_model(); run_meas(5); compare("start_stop");
    check("start_stop.hand_start_amp", start_amp, 90);
    if (obs_tof.size() > 0) begin
      check("start_stop.hand_tof", obs_tof[0], 30);
      check("start_stop.hand_amp", obs_amp[0], 70);
      check("start_stop.hand_when", obs_tag[0], 44);
    end

    // Two-sample noise burst between start and stop.
    wave[20] = 8'd60; wave[21] = 8'd60;
    run_model(); run_meas(5); compare("noise");
    check("noise.hand_n", obs_tof.size(), 1);
    if (obs_idx.size() > 0) check("noise.hand_idx", obs_idx[0], 0);

    // Hysteresis dip and equal peaks.
    clear_wave();
    put6(10, 20, 50, 90, 60, 20, 0);
    put6(40, 50, 35, 50, 90, 90, 20);
    run_model(); run_meas(5); compare("hyst");
    check("hyst.hand_n", obs_tof.size(), 1);
    if (obs_tof.size() > 0) begin
      check("hyst.hand_tof", obs_tof[0], 31);
      check("hyst.hand_amp", obs_amp[0], 90);
    end

    // Full measurement: six stops offered, five counted.
    clear_wave();
    put6(10, 20, 50, 90, 60, 20, 0);
    for (int i = 0; i < 6; i++) put6(40 + 10 * i, 45, 60, 45, 0, 0, 0);
    run_model(); run_meas(30); compare("full");
    check("full.hand_n", obs_tof.size(), 5);
    for (int i = 0; i < obs_tof.size(); i++) begin
      check($sformatf("full.hand_idx%0d", i), obs_idx[i], i);
      check($sformatf("full.hand_tof%0d", i), obs_tof[i], 29 + 10 * i);
    end
    check("full.hand_done_tag", obs_done_tag, 83);
    check("full.hand_timeout", timeout, 0);
    check("full.hand_count", stop_count, 5);

    // Timeout with only a start pulse.
    clear_wave();
    put6(10, 20, 50, 90, 60, 20, 0);
    run_model(); run_meas(3); compare("timeout");
    check("timeout.hand_done_tag", obs_done_tag, 999);
    check("timeout.hand_flag", timeout, 1);
    check("timeout.hand_count", stop_count, 0);

    // Table-driven single-measurement vectors.
    for (int v = 0; v < 7; v++) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      clear_wave();
      put_pulse(vecs[v].t0, vecs[v].w0, vecs[v].k0);
      put_pulse(vecs[v].t1, vecs[v].w1, vecs[v].k1);
      put_pulse(vecs[v].t2, vecs[v].w2, vecs[v].k2);
      run_meas(5);
      check({nm, ".count"}, stop_count, vecs[v].e_cnt);
      check({nm, ".n_strobes"}, obs_tof.size(), vecs[v].e_cnt);
      if (vecs[v].e_cnt > 0 && obs_tof.size() > 0) begin
        check({nm, ".tof"}, obs_tof[0], vecs[v].e_tof);
        check({nm, ".amp"}, obs_amp[0], vecs[v].e_amp);
      end
      check({nm, ".start_amp"}, start_amp, vecs[v].e_samp);
      check({nm, ".timeout"}, timeout, 1);
      check({nm, ".done_tag"}, obs_done_tag, WINDOW - 1);
    end

    // Abort by reset in the middle of a stop pulse.
    clear_wave();
    put6(10, 20, 50, 90, 60, 20, 0);
    put6(40, 10, 45, 70, 45, 10, 0);
    @(negedge clk); arm = 1'b1;
    @(negedge clk); arm = 1'b0; sample = wave[0];
    for (int k = 0; k < 42; k++) begin
      @(negedge clk); sample = wave[k+1];
    end
    #2 reset = 1'b0;
    #1 check_all_zero("abort");
    begin
      int strobes;
      strobes = 0;
      for (int k = 43; k < 50; k++) begin
        @(negedge clk);
        if (stop_valid || done) strobes++;
        sample = wave[k];
        if (k == 45) reset = 1'b1;
      end
      check("abort.no_strobe", strobes, 0);
      check("abort.busy", busy, 0);
      check("abort.stop_count", stop_count, 0);
    end
    sample = 8'd0;

    // Randomized waveforms against the reference model.
    for (int r = 0; r < 12; r++) begin
      int t, w, g, gmax;
      clear_wave();
      gmax = (r % 2 == 1) ? 40 : 250;
      t = int'($urandom_range(0, 20));
      while (t < 1150) begin
        w = int'($urandom_range(1, 6));
        for (int i = 0; i < w && t < 1150; i++) begin
          wave[t] = (i == 0) ? 8'($urandom_range(40, 255)) : 8'($urandom_range(32, 255));
          t++;
        end
        g = int'($urandom_range(1, gmax));
        for (int i = 0; i < g && t < 1150; i++) begin
          wave[t] = 8'($urandom_range(0, 31));
          t++;
        end
      end
      run_model(); run_meas(15); compare($sformatf("rnd%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
